reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 9: register data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: number of registers, power of two, at least 2.
REQ-003 SHALL have parameter RT_AW, default 2: address width of the rt/rd/lock window (low 2**RT_AW registers), at most $clog2(DEPTH).
REQ-004 SHALL have parameter ZERO_R0, default 0: when 1, register 0 reads zero and is never written or locked.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge active.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port write, input, 1 bit: write enable for rd_in into rd_addr.
REQ-008 SHALL have port rs_addr, input, $clog2(DEPTH) bits: read port S address (full range).
REQ-009 SHALL have port rt_addr, input, RT_AW bits: read port T address (window).
REQ-010 SHALL have port rd_addr, input, RT_AW bits: write address (window).
REQ-011 SHALL have port rd_in, input, WIDTH bits: write data.
REQ-012 SHALL have port lock, input, 1 bit: mark lock_addr as pending-write (busy).
REQ-013 SHALL have port lock_addr, input, RT_AW bits: register to lock.
REQ-014 SHALL have port rs_out, output, WIDTH bits: read port S data.
REQ-015 SHALL have port rt_out, output, WIDTH bits: read port T data.
REQ-016 SHALL have port rs_busy, output, 1 bit: busy bit of rs_addr, 0 when rs_addr is outside the window.
REQ-017 SHALL have port rt_busy, output, 1 bit: busy bit of rt_addr.
REQ-018 SHALL have port lock_err, output, 1 bit: one-cycle pulse flagging a lock on an already-busy register.

Function
REQ-019 SHALL provide combinational reads: rs_out = regs[rs_addr], rt_out = regs[rt_addr].
REQ-020 SHALL, on a rising clk edge with write=1, load rd_in into regs[rd_addr] and clear busy[rd_addr].
REQ-021 SHALL, on a rising clk edge with lock=1, set busy[lock_addr].
REQ-022 SHALL, on simultaneous write and lock to the same address, store the data and leave busy set (lock wins).
REQ-023 SHALL, when lock targets a register already busy and not written that cycle, assert lock_err for exactly the following cycle; busy stays 1.
REQ-024 SHALL, when ZERO_R0=1, ignore writes and locks to address 0, return 0 on reads of it and report its busy bit as 0.
REQ-025 SHALL keep only 2**RT_AW busy bits; registers outside the window are never busy.
REQ-026 SHALL leave registers not addressed by a write unchanged.

Reset
REQ-027 SHALL, on reset assertion and independently of clk, clear all registers, all busy bits and lock_err to 0.
REQ-028 SHALL hold all state at 0 while reset is high, ignoring write and lock.
REQ-029 SHALL, when reset asserts in the same cycle as a write, discard the write.

Configuration
REQ-030 SHALL, with macro REG_FILE_BYPASS_EN defined, forward rd_in to rs_out/rt_out combinationally when write=1 and the read address equals rd_addr (zero-extended), and report that busy bit as 0 unless lock targets the same address that cycle.
REQ-031 SHALL, without REG_FILE_BYPASS_EN, return pre-edge register contents and busy bits; new data and busy bits become visible after the edge.
REQ-032 SHALL give ZERO_R0 precedence over bypass for address 0.

Structure
REQ-033 SHALL place default WIDTH/DEPTH/RT_AW constants, typedef reg_word_t and the address typedefs in package reg_file_pkg.
REQ-034 SHALL implement the busy bits and lock_err in sub-module reg_file_scoreboard, instantiated once.

Verification
REQ-035 SHALL cover reset then write: reset pulse, write=1, rd_addr=2, rd_in=255, 1 edge -> rt_addr=2 gives rt_out=255; rs_addr=8 gives rs_out=0.
REQ-036 SHALL cover lock then write: lock_addr=1, edge -> rt_busy=1 at rt_addr=1; write rd_addr=1, rd_in=0x1AB, edge -> rt_busy=0, rt_out=0x1AB.
REQ-037 SHALL cover double lock: lock_addr=3 on two consecutive edges -> lock_err=1 for the cycle after the second edge only, busy[3]=1.
REQ-038 SHALL cover bypass: write=1, rd_addr=0, rd_in=5, rs_addr=0, ZERO_R0=0 -> rs_out=5 before the edge with REG_FILE_BYPASS_EN, previous value without.
REQ-039 SHALL cover async reset mid-operation: regs[1]=7, busy[2]=1, reset high between edges -> rt_out=0, rt_busy=0 immediately, held at 0 while reset is high.
REQ-040 SHALL cover ZERO_R0=1: write rd_addr=0, rd_in=9 and lock_addr=0 -> rt_out=0 and rt_busy=0 at rt_addr=0, lock_err stays 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the scoreboarded register file.
// The default widths here match the default parameters of reg_file_sb.
package reg_file_pkg;

  localparam int DEFAULT_WIDTH = 9;
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_RT_AW = 2;
  localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

  typedef logic [DEFAULT_WIDTH-1:0] reg_word_t;
  typedef logic [DEFAULT_AW-1:0]    reg_addr_t;
  typedef logic [DEFAULT_RT_AW-1:0] rt_addr_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard for the low 2**RT_AW registers of reg_file_sb.
// A lock marks a register as waiting for a write; the write clears it.
// Lock beats a same-cycle write to the same register. Locking a register
// that is already busy (and not being written) raises lock_err for one cycle.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int RT_AW   = DEFAULT_RT_AW,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write,
  input  logic [RT_AW-1:0]        rd_addr,
  input  logic                    lock,
  input  logic [RT_AW-1:0]        lock_addr,
  output logic [(2**RT_AW)-1:0]   busy,
  output logic                    lock_err
);

  localparam int NB = 2**RT_AW;

  logic [NB-1:0] busy_reg;
  logic [NB-1:0] busy_next;
  logic          lock_err_reg;
  logic          lock_err_next;

  // Per-register next busy value: lock sets, write clears, lock has priority.
  for (genvar gi = 0; gi < NB; gi++) begin : g_busy
    localparam logic [RT_AW-1:0] IDX = RT_AW'(gi);
    logic set_hit;
    logic clr_hit;
    assign set_hit = lock && (lock_addr == IDX);
    assign clr_hit = write && (rd_addr == IDX);
    assign busy_next[gi] = (ZERO_R0 && (gi == 0)) ? 1'b0 :
                           set_hit                ? 1'b1 :
                           clr_hit                ? 1'b0 : busy_reg[gi];
  end

  // Re-locking a busy register that is not being written this cycle is an error.
  always_comb begin
    lock_err_next = lock && busy_reg[lock_addr] && !(write && (rd_addr == lock_addr));
  end

  // Busy bits and error flag; cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg     <= '0;
      lock_err_reg <= 1'b0;
    end else begin
      busy_reg     <= busy_next;
      lock_err_reg <= lock_err_next;
    end
  end

  assign busy     = busy_reg;
  assign lock_err = lock_err_reg;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port and a
// busy-bit scoreboard over the low 2**RT_AW registers.
// Optional build macro REG_FILE_BYPASS_EN: forwards same-cycle write data
// (and the resulting busy state) to the read ports.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int RT_AW   = DEFAULT_RT_AW,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [$clog2(DEPTH)-1:0] rs_addr,
  input  logic [RT_AW-1:0]         rt_addr,
  input  logic [RT_AW-1:0]         rd_addr,
  input  logic [WIDTH-1:0]         rd_in,
  input  logic                     lock,
  input  logic [RT_AW-1:0]         lock_addr,
  output logic [WIDTH-1:0]         rs_out,
  output logic [WIDTH-1:0]         rt_out,
  output logic                     rs_busy,
  output logic                     rt_busy,
  output logic                     lock_err
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]       regs_reg [DEPTH];
  logic [DEPTH-1:0]       wr_en;
  logic [(2**RT_AW)-1:0]  busy;
  logic [AW-1:0]          rd_ext;
  logic [AW-1:0]          rt_ext;
  logic                   rs_in_win;

  assign rd_ext = AW'(rd_addr);
  assign rt_ext = AW'(rt_addr);

  // Write decode; register 0 is write-protected when hardwired to zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    localparam logic [AW-1:0] IDX = AW'(gi);
    assign wr_en[gi] = write && (rd_ext == IDX) && !(ZERO_R0 && (gi == 0));
  end

  // rs can address the whole file; only the low window carries busy bits.
  if (RT_AW < AW) begin : g_win
    assign rs_in_win = (rs_addr[AW-1:RT_AW] == '0);
  end else begin : g_full
    assign rs_in_win = 1'b1;
  end

  // Register storage, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (wr_en[i]) regs_reg[i] <= rd_in;
    end
  end

  reg_file_scoreboard #(
    .RT_AW   (RT_AW),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .rd_addr   (rd_addr),
    .lock      (lock),
    .lock_addr (lock_addr),
    .busy      (busy),
    .lock_err  (lock_err)
  );

  // Read port S: data and busy, with optional forwarding; zero register wins.
  always_comb begin
    rs_out  = regs_reg[rs_addr];
    rs_busy = rs_in_win ? busy[rs_addr[RT_AW-1:0]] : 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (write && (rs_addr == rd_ext)) begin
      rs_out  = rd_in;
      rs_busy = lock && (lock_addr == rd_addr);
    end
`endif
    if (ZERO_R0 && (rs_addr == '0)) begin
      rs_out  = '0;
      rs_busy = 1'b0;
    end
  end

  // Read port T: same rules, always inside the busy window.
  always_comb begin
    rt_out  = regs_reg[rt_ext];
    rt_busy = busy[rt_addr];
`ifdef REG_FILE_BYPASS_EN
    if (write && (rt_addr == rd_addr)) begin
      rt_out  = rd_in;
      rt_busy = lock && (lock_addr == rd_addr);
    end
`endif
    if (ZERO_R0 && (rt_addr == '0)) begin
      rt_out  = '0;
      rt_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: two instances (ZERO_R0=0 and 1)
// share the same stimulus and are compared against an array-based model.
module tb_reg_file_sb;
  import reg_file_pkg::*;

  logic      clk = 1'b0;
  logic      reset = 1'b1;
  logic      write = 1'b0;
  logic      lock = 1'b0;
  reg_addr_t rs_addr = '0;
  rt_addr_t  rt_addr = '0;
  rt_addr_t  rd_addr = '0;
  rt_addr_t  lock_addr = '0;
  reg_word_t rd_in = '0;

  reg_word_t rs_out [2];
  reg_word_t rt_out [2];
  logic      rs_busy [2];
  logic      rt_busy [2];
  logic      lock_err [2];

  int total = 0;
  int bad = 0;

  // reference state: index 0 = plain instance, 1 = ZERO_R0 instance
  int mem [2][16];
  bit bsy [2][4];
  bit err [2];

  always #5 clk = ~clk;

  reg_file_sb #(.ZERO_R0(1'b0)) dut (
    .clk(clk), .reset(reset), .write(write), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .rd_in(rd_in), .lock(lock), .lock_addr(lock_addr),
    .rs_out(rs_out[0]), .rt_out(rt_out[0]), .rs_busy(rs_busy[0]), .rt_busy(rt_busy[0]),
    .lock_err(lock_err[0])
  );

  reg_file_sb #(.ZERO_R0(1'b1)) dut_z (
    .clk(clk), .reset(reset), .write(write), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .rd_in(rd_in), .lock(lock), .lock_addr(lock_addr),
    .rs_out(rs_out[1]), .rt_out(rt_out[1]), .rs_busy(rs_busy[1]), .rt_busy(rt_busy[1]),
    .lock_err(lock_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_data(int m, int a);
    if (m == 1 && a == 0) return 0;
`ifdef REG_FILE_BYPASS_EN
    if (write && a == int'(rd_addr)) return int'(rd_in);
`endif
    return mem[m][a];
  endfunction

  function automatic int exp_busy(int m, int a);
    if (a >= 4) return 0;
    if (m == 1 && a == 0) return 0;
`ifdef REG_FILE_BYPASS_EN
    if (write && a == int'(rd_addr)) return (lock && int'(lock_addr) == a) ? 1 : 0;
`endif
    return bsy[m][a] ? 1 : 0;
  endfunction

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk(m ? "z_rs_out" : "rs_out", 32'(rs_out[m]), 32'(exp_data(m, int'(rs_addr))));
      chk(m ? "z_rt_out" : "rt_out", 32'(rt_out[m]), 32'(exp_data(m, int'(rt_addr))));
      chk(m ? "z_rs_busy" : "rs_busy", 32'(rs_busy[m]), 32'(exp_busy(m, int'(rs_addr))));
      chk(m ? "z_rt_busy" : "rt_busy", 32'(rt_busy[m]), 32'(exp_busy(m, int'(rt_addr))));
      chk(m ? "z_lock_err" : "lock_err", 32'(lock_err[m]), 32'(err[m]));
    end
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) mem[m][a] = 0;
      for (int a = 0; a < 4; a++) bsy[m][a] = 1'b0;
      err[m] = 1'b0;
    end
  endtask

  // Apply the rules of one rising edge to the model, using the held inputs.
  task automatic model_edge();
    int rd, la;
    bit e;
    rd = int'(rd_addr);
    la = int'(lock_addr);
    if (reset) begin
      model_clear();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      e = lock && bsy[m][la] && !(write && rd == la) && !(m == 1 && la == 0);
      if (write && !(m == 1 && rd == 0)) begin
        mem[m][rd] = int'(rd_in);
        bsy[m][rd] = 1'b0;
      end
      if (lock && !(m == 1 && la == 0)) bsy[m][la] = 1'b1;
      err[m] = e;
    end
  endtask

  task automatic drive(input bit w, input int rda, input int din, input bit lk,
                       input int la, input int rsa, input int rta);
    @(negedge clk);
    write = w;
    rd_addr = rt_addr_t'(rda);
    rd_in = reg_word_t'(din);
    lock = lk;
    lock_addr = rt_addr_t'(la);
    rs_addr = reg_addr_t'(rsa);
    rt_addr = rt_addr_t'(rta);
    #1;
    check_all();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 511),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
            $urandom_range(0, 15), $urandom_range(0, 3));
      clock_edge();
    end
  endtask

  initial begin
    model_clear();
    #2;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);

    // reset then write
    drive(1, 2, 255, 0, 0, 8, 2);
    clock_edge();
    drive(0, 0, 0, 0, 0, 8, 2);
    chk("t_wr_rt_out", 32'(rt_out[0]), 32'd255);
    chk("t_wr_rs_out", 32'(rs_out[0]), 32'd0);
    clock_edge();

    // forwarding of write data to a read of the same address
    drive(1, 0, 5, 0, 0, 0, 0);
`ifdef REG_FILE_BYPASS_EN
    chk("t_byp_rs_out", 32'(rs_out[0]), 32'd5);
`else
    chk("t_byp_rs_out", 32'(rs_out[0]), 32'd0);
`endif
    chk("t_byp_z_rs_out", 32'(rs_out[1]), 32'd0);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t_byp_after", 32'(rs_out[0]), 32'd5);
    clock_edge();

    // lock then write
    drive(0, 0, 0, 1, 1, 0, 1);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t_lock_busy", 32'(rt_busy[0]), 32'd1);
    clock_edge();
    drive(1, 1, 'h1AB, 0, 0, 0, 1);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t_wr_unbusy", 32'(rt_busy[0]), 32'd0);
    chk("t_wr_data", 32'(rt_out[0]), 32'h1AB);
    clock_edge();

    // double lock on register 3
    drive(0, 0, 0, 1, 3, 0, 3);
    clock_edge();
    drive(0, 0, 0, 1, 3, 0, 3);
    chk("t_dl_no_err_yet", 32'(lock_err[0]), 32'd0);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 3);
    chk("t_dl_err", 32'(lock_err[0]), 32'd1);
    chk("t_dl_busy", 32'(rt_busy[0]), 32'd1);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 3);
    chk("t_dl_err_gone", 32'(lock_err[0]), 32'd0);
    clock_edge();

    // register 0 hardwired to zero on the ZERO_R0 instance
    drive(1, 0, 9, 1, 0, 0, 0);
    clock_edge();
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t_z_rt_out", 32'(rt_out[1]), 32'd0);
    chk("t_z_rt_busy", 32'(rt_busy[1]), 32'd0);
    clock_edge();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t_z_lock_err", 32'(lock_err[1]), 32'd0);
    chk("t_nz_lock_err", 32'(lock_err[0]), 32'd1);
    clock_edge();

    rand_cycles(300);

    // asynchronous reset between edges
    drive(1, 1, 7, 1, 2, 1, 2);
    clock_edge();
    drive(0, 0, 0, 0, 0, 1, 2);
    chk("t_ar_pre_data", 32'(rs_out[0]), 32'd7);
    chk("t_ar_pre_busy", 32'(rt_busy[0]), 32'd1);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    chk("t_ar_data", 32'(rs_out[0]), 32'd0);
    chk("t_ar_busy", 32'(rt_busy[0]), 32'd0);
    write = 1'b1;
    rd_addr = 2'd3;
    rd_in = 9'h055;
    lock = 1'b1;
    lock_addr = 2'd1;
    clock_edge();
    #1;
    chk("t_ar_hold_data", 32'(rs_out[0]), 32'd0);
    chk("t_ar_hold_busy", 32'(rt_busy[0]), 32'd0);
    chk("t_ar_hold_err", 32'(lock_err[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    write = 1'b0;
    lock = 1'b0;
    #1;
    check_all();
    clock_edge();
    drive(0, 0, 0, 0, 0, 3, 1);
    chk("t_ar_wr_dropped", 32'(rs_out[0]), 32'd0);
    chk("t_ar_lock_dropped", 32'(rt_busy[0]), 32'd0);
    clock_edge();

    rand_cycles(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
